// File: rtl/instr_fetch.sv
// instr_fetch: stage 1 (I) front end of the 3-stage RV32 pipeline.
//   Owns the fetch PC, drives the synchronous-read icache and flushes on a
//   redirect from stage X. A hold buffer keeps the fetched word while the
//   pipeline is stalled, so the icache read enable can drop. A redirect seen
//   during a stall is parked and taken when the stall clears.
//
// Ports:
//   i_clk              clock, all state updates on posedge
//   i_reset            synchronous active-high reset
//   i_stall            downstream will not latch o_pc_out/o_inst_out this cycle
//   i_redirect_valid   stage X resolved a taken branch/jump this cycle
//   i_redirect_pc      redirect target byte address (low two bits ignored)
//   o_icache_addr      fetch byte address; data returns on i_icache_dout next cycle
//   o_icache_re        icache read enable
//   i_icache_dout      instruction word for the address issued last cycle
//   o_pc_out           PC of o_inst_out
//   o_inst_out         instruction to stage 2, `INSTR_NOP when flushed/invalid
//   o_inst_valid       o_inst_out is a real fetched instruction
//   o_fetch_cnt        perf: instructions delivered
//   o_flush_cnt        perf: redirects taken (instructions killed)
//
// Configuration macro FETCH_PERF_CNT_EN: when defined the two perf counters
// are built; otherwise both count outputs are tied to zero.

`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_icache_addr,
    output logic        o_icache_re,
    input  logic [31:0] i_icache_dout,
    output logic [31:0] o_pc_out,
    output logic [31:0] o_inst_out,
    output logic        o_inst_valid,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_flush_cnt
);

    typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

    state_e      r_state;
    logic [31:0] r_pc_f;     // PC whose word is on i_icache_dout (RUN) or in r_hold (HOLD)
    logic [31:0] r_hold;
    logic        r_pend;
    logic [31:0] r_pend_pc;

    logic        w_take;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    assign w_pc_inc = r_pc_f + 32'd4;
    // A live redirect beats a parked one; targets are word aligned.
    assign w_target = (i_redirect_valid ? i_redirect_pc : r_pend_pc) & 32'hFFFF_FFFC;
    assign w_take   = (r_state != StBoot) && !i_stall && (i_redirect_valid || r_pend);

    // Outputs are combinational so a redirect kills the current word in the same cycle.
    always_comb begin
        o_icache_re   = 1'b0;
        o_icache_addr = RESET_PC;
        o_pc_out      = 32'd0;
        o_inst_out    = `INSTR_NOP;
        o_inst_valid  = 1'b0;
        if (!i_reset) begin
            unique case (r_state)
                StBoot: begin
                    o_icache_re = 1'b1;
                    o_pc_out    = RESET_PC;
                end
                StRun, StHold: begin
                    o_pc_out      = r_pc_f;
                    o_icache_addr = w_pc_inc;
                    if (w_take) begin
                        o_icache_re   = 1'b1;
                        o_icache_addr = w_target;
                    end else begin
                        o_inst_valid = 1'b1;
                        o_inst_out   = (r_state == StRun) ? i_icache_dout : r_hold;
                        o_icache_re  = !i_stall;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StBoot;
            r_pc_f    <= RESET_PC;
            r_hold    <= `INSTR_NOP;
            r_pend    <= 1'b0;
            r_pend_pc <= 32'd0;
        end else begin
            unique case (r_state)
                StBoot: r_state <= StRun;
                StRun, StHold: begin
                    if (w_take) begin
                        r_pc_f  <= w_target;
                        r_pend  <= 1'b0;
                        r_state <= StRun;
                    end else if (i_stall) begin
                        // Capture only on the RUN->HOLD edge; dout is undefined afterwards.
                        if (r_state == StRun) begin
                            r_hold <= i_icache_dout;
                        end
                        if (i_redirect_valid) begin
                            r_pend    <= 1'b1;
                            r_pend_pc <= i_redirect_pc;
                        end
                        r_state <= StHold;
                    end else begin
                        r_pc_f  <= w_pc_inc;
                        r_state <= StRun;
                    end
                end
                default: r_state <= StBoot;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fetch_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (!i_stall && o_inst_valid) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_take) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_flush_cnt = r_flush_cnt;
`else
    assign o_fetch_cnt = 32'd0;
    assign o_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch.
//   A behavioural model tracks which PC must be presented next, any parked
//   redirect, and the perf counts; instruction words are checked as mem(pc).
//   Directed scenarios with literal expectations are followed by random traffic.

module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_2000;
`ifdef INSTR_NOP
    localparam logic [31:0] NOP = `INSTR_NOP;
`else
    localparam logic [31:0] NOP = 32'h0000_0013;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] dout;
    logic [31:0] addr;
    logic        re;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_stall         (stall),
        .i_redirect_valid(rv),
        .i_redirect_pc   (rpc),
        .o_icache_addr   (addr),
        .o_icache_re     (re),
        .i_icache_dout   (dout),
        .o_pc_out        (pc_out),
        .o_inst_out      (inst_out),
        .o_inst_valid    (inst_valid),
        .o_fetch_cnt     (fetch_cnt),
        .o_flush_cnt     (flush_cnt)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous-read icache; garbage after a cycle without read enable.
    always @(posedge clk) dout <= re ? mem_word(addr) : $urandom;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    logic        m_boot    = 1'b0;
    logic [31:0] m_pc      = 32'd0;
    logic        m_pend    = 1'b0;
    logic [31:0] m_pend_pc = 32'd0;
    logic [31:0] m_fetch   = 32'd0;
    logic [31:0] m_flush   = 32'd0;

    initial begin
        logic [31:0] tgt;
        @(posedge clk);
        forever begin
            @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
            check("fetch_cnt", fetch_cnt, m_fetch);
            check("flush_cnt", flush_cnt, m_flush);
`else
            check("fetch_cnt", fetch_cnt, 32'd0);
            check("flush_cnt", flush_cnt, 32'd0);
`endif
            if (reset) begin
                check("rst_re", {31'd0, re}, 32'd0);
                check("rst_addr", addr, RESET_PC);
                check("rst_pc", pc_out, 32'd0);
                check("rst_inst", inst_out, NOP);
                check("rst_valid", {31'd0, inst_valid}, 32'd0);
                m_boot  = 1'b1;
                m_pend  = 1'b0;
                m_pc    = RESET_PC;
                m_fetch = 32'd0;
                m_flush = 32'd0;
            end else if (m_boot) begin
                check("boot_re", {31'd0, re}, 32'd1);
                check("boot_addr", addr, RESET_PC);
                check("boot_pc", pc_out, RESET_PC);
                check("boot_inst", inst_out, NOP);
                check("boot_valid", {31'd0, inst_valid}, 32'd0);
                m_boot = 1'b0;
                m_pc   = RESET_PC;
            end else if (!stall && (rv || m_pend)) begin
                tgt = (rv ? rpc : m_pend_pc) & 32'hFFFF_FFFC;
                check("kill_valid", {31'd0, inst_valid}, 32'd0);
                check("kill_inst", inst_out, NOP);
                check("kill_re", {31'd0, re}, 32'd1);
                check("kill_addr", addr, tgt);
                m_pc    = tgt;
                m_pend  = 1'b0;
                m_flush = m_flush + 32'd1;
            end else begin
                check("run_valid", {31'd0, inst_valid}, 32'd1);
                check("run_pc", pc_out, m_pc);
                check("run_inst", inst_out, mem_word(m_pc));
                if (stall) begin
                    check("stall_re", {31'd0, re}, 32'd0);
                    if (rv) begin
                        m_pend    = 1'b1;
                        m_pend_pc = rpc;
                    end
                end else begin
                    check("run_re", {31'd0, re}, 32'd1);
                    check("run_addr", addr, m_pc + 32'd4);
                    m_pc    = m_pc + 32'd4;
                    m_fetch = m_fetch + 32'd1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic st, input logic v, input logic [31:0] pc);
        @(posedge clk);
        #1;
        stall = st;
        rv    = v;
        rpc   = pc;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        rv    = 1'b0;
        rpc   = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Boot cycle
        @(negedge clk);
        check("t1_boot_addr", addr, 32'h0000_2000);
        check("t1_boot_inst", inst_out, NOP);

        // Straight-line fetch
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 32'd0);
            @(negedge clk);
            check("t2_pc", pc_out, 32'h0000_2000 + 32'(4 * k));
            check("t2_addr", addr, 32'h0000_2004 + 32'(4 * k));
        end

        // Stall three cycles on 0x2014
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 32'd0);
            @(negedge clk);
            check("t3_re", {31'd0, re}, 32'd0);
            check("t3_pc", pc_out, 32'h0000_2014);
            check("t3_inst", inst_out, mem_word(32'h0000_2014));
        end
        drive(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t3_rel_addr", addr, 32'h0000_2018);
        drive(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t3_next_pc", pc_out, 32'h0000_2018);

        // Unaligned immediate redirect
        drive(1'b0, 1'b1, 32'h0000_3003);
        @(negedge clk);
        check("t4_valid", {31'd0, inst_valid}, 32'd0);
        check("t4_addr", addr, 32'h0000_3000);
        drive(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t4_pc", pc_out, 32'h0000_3000);
        check("t4_inst", inst_out, mem_word(32'h0000_3000));

        // Two redirects during a stall; latest wins
        drive(1'b1, 1'b1, 32'h0000_4000);
        drive(1'b1, 1'b1, 32'h0000_5000);
        drive(1'b1, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t5_valid", {31'd0, inst_valid}, 32'd0);
        check("t5_addr", addr, 32'h0000_5000);
        drive(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t5_pc", pc_out, 32'h0000_5000);
`ifdef FETCH_PERF_CNT_EN
        check("t5_flush_cnt", flush_cnt, 32'd2);
`else
        check("t5_flush_cnt", flush_cnt, 32'd0);
`endif

        // PC wrap
        drive(1'b0, 1'b1, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t6_pc_top", pc_out, 32'hFFFF_FFFC);
        check("t6_addr_wrap", addr, 32'h0000_0000);
        drive(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t6_pc_zero", pc_out, 32'h0000_0000);

        // Reset during HOLD with a parked redirect
        drive(1'b1, 1'b1, 32'h0000_7000);
        drive(1'b1, 1'b0, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        check("t6_rst_re", {31'd0, re}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t6_boot_addr", addr, RESET_PC);
        drive(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        check("t6_pc_after_rst", pc_out, RESET_PC);
        check("t6_valid_after_rst", {31'd0, inst_valid}, 32'd1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            reset = ($urandom_range(199) == 0);
            stall = ($urandom_range(99) < 30);
            rv    = ($urandom_range(99) < 15);
            rpc   = $urandom;
            if ($urandom_range(9) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        stall = 1'b0;
        rv    = 1'b0;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
